key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 12 +
 rtl/key_debounce_sync_2ff.sv | 24 ++
 rtl/key_debounce.sv | 129 ++++++++++++
 tb/tb_key_debounce.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debouncer.
// The state encoding is kept here so other controllers can decode it.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_fsm_e;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so the idle level can be chosen per pin.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with press, release and long-press strobes.
// All outputs are registered; only the synchronized key level is used.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 540_000,
  parameter int LONG_CYCLES     = 27_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int LONG_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

  logic key_sync_n;
  logic key_s;

  key_fsm_e          state, state_next;
  logic [DB_W-1:0]   db_cnt, db_cnt_next;
  logic [LONG_W-1:0] long_cnt, long_cnt_next;
  logic              key_state_next;
  logic              press_next, release_next, long_next;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d         (key_n),
    .q         (key_sync_n)
  );

  assign key_s = ~key_sync_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      long_cnt      <= '0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_next;
      db_cnt        <= db_cnt_next;
      long_cnt      <= long_cnt_next;
      key_state     <= key_state_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_pulse    <= long_next;
    end
  end

  always_comb begin
    state_next     = state;
    db_cnt_next    = db_cnt;
    long_cnt_next  = long_cnt;
    key_state_next = key_state;
    press_next     = 1'b0;
    release_next   = 1'b0;
    long_next      = 1'b0;

    // Hold time keeps accumulating through release bounce, saturating at the threshold.
    if ((state == HELD || state == REL_CHK) && long_cnt != LONG_LAST) begin
      long_cnt_next = long_cnt + LONG_ONE;
      if (long_cnt == LONG_PRE) begin
        long_next = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (key_s) begin
          state_next  = PRESS_CHK;
          db_cnt_next = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next     = HELD;
          db_cnt_next    = '0;
          long_cnt_next  = '0;
          key_state_next = 1'b1;
          press_next     = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_next  = REL_CHK;
          db_cnt_next = '0;
        end
      end
      REL_CHK: begin
        if (key_s) begin
          state_next = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_next     = IDLE;
          db_cnt_next    = '0;
          key_state_next = 1'b0;
          release_next   = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed testbench for key_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
module tb_key_debounce;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_n;
  logic key_state;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_press, n_rel, n_long;
  int at_press, at_rel, at_long;

  key_debounce #(
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .key_n         (key_n),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  // One rising edge, then sample 1 ns later and log any strobes with their edge number.
  task automatic step();
    @(posedge sys_clk);
    cyc++;
    #1;
    if (press_pulse)   begin n_press++; at_press = cyc; end
    if (release_pulse) begin n_rel++;   at_rel   = cyc; end
    if (long_pulse)    begin n_long++;  at_long  = cyc; end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_mon();
    n_press = 0; n_rel = 0; n_long = 0;
    at_press = -1; at_rel = -1; at_long = -1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    key_n     = 1'b1;
    clear_mon();
    run(2);
    checks++;
    if ({key_state, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want 0000",
               {key_state, press_pulse, release_pulse, long_pulse});
    end
    sys_rst_n = 1'b1;
    run(5);
    checks++;
    if (n_press + n_rel + n_long !== 0 || key_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset pulses %0d key_state %b want 0 0",
               n_press + n_rel + n_long, key_state);
    end
  endtask

  task automatic test_clean_press();
    int c;
    clear_mon();
    c = cyc;
    key_n = 1'b0;
    run(10);
    checks++;
    if (n_press !== 0 || key_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_early press %0d key_state %b want 0 0", n_press, key_state);
    end
    run(4);
    checks++;
    if (at_press !== c + 11 || n_press !== 1) begin
      errors++;
      $display("[TB] FAIL clean_press at %0d count %0d want %0d 1", at_press, n_press, c + 11);
    end
    checks++;
    if (key_state !== 1'b1 || n_rel !== 0 || n_long !== 0) begin
      errors++;
      $display("[TB] FAIL clean_state key_state %b rel %0d long %0d want 1 0 0",
               key_state, n_rel, n_long);
    end
    c = cyc;
    key_n = 1'b1;
    run(14);
    checks++;
    if (at_rel !== c + 11 || n_rel !== 1 || key_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_release at %0d count %0d key_state %b want %0d 1 0",
               at_rel, n_rel, key_state, c + 11);
    end
  endtask

  task automatic test_bounce();
    int c;
    clear_mon();
    c = cyc;
    key_n = 1'b0;
    run(5);
    key_n = 1'b1;
    run(1);
    key_n = 1'b0;
    run(14);
    checks++;
    if (at_press !== c + 17 || n_press !== 1) begin
      errors++;
      $display("[TB] FAIL bounce_press at %0d count %0d want %0d 1", at_press, n_press, c + 17);
    end
    key_n = 1'b1;
    run(14);
    checks++;
    if (n_rel !== 1 || key_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_release count %0d key_state %b want 1 0", n_rel, key_state);
    end
  endtask

  task automatic test_long_hold();
    int c;
    clear_mon();
    c = cyc;
    key_n = 1'b0;
    run(60);
    checks++;
    if (at_press !== c + 11 || n_long !== 1 || at_long !== c + 42) begin
      errors++;
      $display("[TB] FAIL long_pulse press %0d long %0d count %0d want %0d %0d 1",
               at_press, at_long, n_long, c + 11, c + 42);
    end
    c = cyc;
    key_n = 1'b1;
    run(14);
    checks++;
    if (at_rel !== c + 11 || n_rel !== 1 || n_long !== 1) begin
      errors++;
      $display("[TB] FAIL long_release at %0d count %0d long %0d want %0d 1 1",
               at_rel, n_rel, n_long, c + 11);
    end
  endtask

  task automatic test_release_glitch();
    int c;
    clear_mon();
    c = cyc;
    key_n = 1'b0;
    run(16);
    key_n = 1'b1;
    run(3);
    key_n = 1'b0;
    run(31);
    checks++;
    if (n_rel !== 0 || key_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_no_release count %0d key_state %b want 0 1", n_rel, key_state);
    end
    checks++;
    if (at_long !== c + 42 || n_long !== 1) begin
      errors++;
      $display("[TB] FAIL glitch_long at %0d count %0d want %0d 1", at_long, n_long, c + 42);
    end
    c = cyc;
    key_n = 1'b1;
    run(14);
    checks++;
    if (at_rel !== c + 11 || n_long !== 1) begin
      errors++;
      $display("[TB] FAIL glitch_release at %0d long %0d want %0d 1", at_rel, n_long, c + 11);
    end
  endtask

  task automatic test_reset_mid_press();
    int c;
    clear_mon();
    c = cyc;
    key_n = 1'b0;
    run(6);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({key_state, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got %b want 0000",
               {key_state, press_pulse, release_pulse, long_pulse});
    end
    run(2);
    sys_rst_n = 1'b1;
    run(14);
    checks++;
    if (at_press !== c + 19 || n_press !== 1) begin
      errors++;
      $display("[TB] FAIL midreset_press at %0d count %0d want %0d 1", at_press, n_press, c + 19);
    end
    key_n = 1'b1;
    run(14);
    checks++;
    if (n_rel !== 1 || key_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_release count %0d key_state %b want 1 0", n_rel, key_state);
    end
  endtask

  task automatic test_short_glitch();
    clear_mon();
    key_n = 1'b0;
    run(1);
    key_n = 1'b1;
    run(20);
    checks++;
    if (n_press + n_rel + n_long !== 0 || key_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_glitch pulses %0d key_state %b want 0 0",
               n_press + n_rel + n_long, key_state);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_glitch();
    test_reset_mid_press();
    test_short_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
